// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  localparam int unsigned WORD_W = 32'd32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 2 * WORD_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_data,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_s, do_pop_s;

  // A push into a full queue is legal only when the head leaves the same cycle.
  assign do_pop_s  = pop & (count_q != CNT_ZERO);
  assign do_push_s = push & ((count_q != CNT_FULL) | do_pop_s);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: credit-limited requests to imem, in-order queue
// to decode, and redirect handling that drops responses still in flight.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [WORD_W-1:0] imem_resp_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [CNT_W-1:0]    fifo_count_s;
  logic [2*WORD_W-1:0] fifo_head_s;
  logic [CNT_W-1:0]    inflight_s;
  logic                credit_s, req_valid_s, accept_s;
  logic                resp_live_s, push_s, stale_s, pop_s;

  // Queued plus in-flight words may never exceed the queue size, so a
  // response always finds a free slot.
  assign credit_s    = (SUM_W'(fifo_count_s) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
  assign req_valid_s = (state_q == FETCH) & ~redirect_valid & credit_s;
  assign accept_s    = req_valid_s & imem_req_ready;

  assign resp_live_s = imem_resp_valid & (state_q != BOOT);
  assign push_s      = resp_live_s & ~redirect_valid & (drop_q == CNT_ZERO)
                     & (outstanding_q != CNT_ZERO);
  assign stale_s     = resp_live_s & (redirect_valid | (drop_q != CNT_ZERO));
  assign inflight_s  = drop_q + outstanding_q;
  assign pop_s       = out_valid & out_ready;

  // Address, credit and drop bookkeeping plus next state.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    state_d       = state_q;
    if (redirect_valid) begin
      fetch_pc_d    = align_pc(redirect_pc);
      resp_pc_d     = align_pc(redirect_pc);
      outstanding_d = CNT_ZERO;
      drop_d        = inflight_s - CNT_W'(resp_live_s && (inflight_s != CNT_ZERO));
    end else begin
      fetch_pc_d    = accept_s ? (fetch_pc_q + PC_INC) : fetch_pc_q;
      resp_pc_d     = push_s ? (resp_pc_q + PC_INC) : resp_pc_q;
      outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(push_s);
      drop_d        = (stale_s && (drop_q != CNT_ZERO)) ? (drop_q - CNT_W'(1'b1)) : drop_q;
    end
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redirect_valid && (drop_d != CNT_ZERO)) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          state_d = DRAIN;
        end else if (drop_d == CNT_ZERO) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= CNT_ZERO;
      drop_q        <= CNT_ZERO;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (2 * WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data ({resp_pc_q, imem_resp_data}),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .count     (fifo_count_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = (fifo_count_s != CNT_ZERO);
  assign out_pc         = fifo_head_s[2*WORD_W-1:WORD_W];
  assign out_instr      = fifo_head_s[WORD_W-1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a small memory model answers requests in
// order and every decoded word is checked against the accepted addresses.
module tb_fetch_buffer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  bit mem_hold = 1'b0;
  bit mem_flush = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] mon_exp;

  fetch_buffer #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  // Memory: present the oldest pending word just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!mem_hold && pend.size() != 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(pend[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  // Handshake monitor and scoreboard, evaluated mid-cycle before the next edge.
  always @(negedge clk) begin
    #2;
    if (imem_resp_valid && pend.size() != 0) pend.delete(0);
    if (!rst) begin
      exp_q.delete();
      if (mem_flush) pend.delete();
    end else begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: out_pc=%h out_instr=%h, nothing expected", out_pc, out_instr);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_pc !== mon_exp || out_instr !== instr_of(mon_exp)) begin
            failures++;
            $display("FAIL sb_order: got pc=%h instr=%h want pc=%h instr=%h",
                     out_pc, out_instr, mon_exp, instr_of(mon_exp));
          end
        end
      end
      if (redirect_valid) exp_q.delete();
      if (imem_req_valid && imem_req_ready) begin
        exp_q.push_back(imem_req_addr);
        pend.push_back(imem_req_addr);
        acc_log.push_back(imem_req_addr);
        acc_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int ca, co;
    logic [31:0] first_pc;
    logic [31:0] want [4];
    ca = -1; co = -1; first_pc = 32'hFFFF_FFFF;
    want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h8; want[3] = 32'hC;
    #1 rst = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (imem_req_addr !== RST_PC) begin failures++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RST_PC); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    @(negedge clk);
    acc_log.delete();
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #3;
      if (ca < 0 && imem_req_valid && imem_req_ready) ca = c;
      if (co < 0 && out_valid) begin co = c; first_pc = out_pc; end
    end
    checks++; if (ca < 0 || co != ca + 2) begin failures++; $display("FAIL first_latency: accept cycle %0d out cycle %0d, want out = accept+2", ca, co); end
    checks++; if (first_pc !== RST_PC) begin failures++; $display("FAIL first_out_pc: got %h want %h", first_pc, RST_PC); end
    checks++;
    if (acc_log.size() < 4) begin
      failures++; $display("FAIL stream_count: got %0d requests want >=4", acc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc_log[i] !== want[i]) begin failures++; $display("FAIL stream_addr%0d: got %h want %h", i, acc_log[i], want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit found;
    do_reset();
    acc_cnt = 0;
    imem_req_ready = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    checks++; if (acc_cnt != 4) begin failures++; $display("FAIL bp_accepts: got %0d want 4", acc_cnt); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got valid=%b pc=%h want 1/0", out_valid, out_pc); end
    @(negedge clk); #3;
    checks++; if (out_pc !== 32'h0 || out_instr !== instr_of(32'h0)) begin failures++; $display("FAIL bp_hold: got pc=%h instr=%h want 0/%h", out_pc, out_instr, instr_of(32'h0)); end
    @(negedge clk);
    pop_cnt = 0;
    acc_log.delete();
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #3;
      if (acc_log.size() != 0) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL bp_resume: no request within bound, want %h", 32'h10); end
    else if (acc_log[0] !== 32'h10) begin failures++; $display("FAIL bp_resume: got %h want %h", acc_log[0], 32'h10); end
    repeat (10) @(negedge clk);
    checks++; if (pop_cnt < 4) begin failures++; $display("FAIL bp_drain: got %0d pops want >=4", pop_cnt); end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    out_ready = 1'b1;
    mem_hold = 1'b1;
    @(negedge clk);
    acc_cnt = 0;
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    #3;
    checks++; if (acc_cnt != 2) begin failures++; $display("FAIL rd_setup: got %0d accepts want 2", acc_cnt); end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    mem_hold = 1'b0;
    acc_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #3;
    checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rd_drain1: got req=%b out=%b want 0/0", imem_req_valid, out_valid); end
    @(negedge clk); #3;
    checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rd_drain2: got req=%b out=%b want 0/0", imem_req_valid, out_valid); end
    @(negedge clk); #3;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL rd_refetch: got req=%b addr=%h want 1/100", imem_req_valid, imem_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #3;
      if (out_valid) found = 1'b1;
    end
    checks++; if (!found || out_pc !== 32'h100) begin failures++; $display("FAIL rd_first_out: got found=%b pc=%h want 1/100", found, out_pc); end
  endtask

  task automatic test_redirect_collision();
    int p0;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    p0 = pop_cnt;
    checks++; if (imem_resp_valid !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL col_setup: got resp=%b out=%b want 1/1", imem_resp_valid, out_valid); end
    #2;
    checks++; if (pop_cnt != p0 + 1) begin failures++; $display("FAIL col_pop: got %0d pops want %0d", pop_cnt - p0, 1); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL col_flush: got out_valid=%b want 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL col_refetch: got req=%b addr=%h want 1/200", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    bit found;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    acc_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #3;
      if (acc_log.size() >= 2) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL wrap_timeout: got %0d requests want 2", acc_log.size()); end
    else if (acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
      failures++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", acc_log[0], acc_log[1]);
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    acc_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #3;
      if (acc_log.size() >= 1) found = 1'b1;
    end
    checks++;
    if (!found || acc_log[0] !== 32'h100) begin failures++; $display("FAIL align_addr: got found=%b addr=%h want 1/100", found, found ? acc_log[0] : 32'h0); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #3;
      if (out_valid) found = 1'b1;
    end
    checks++; if (!found || out_pc !== 32'h100) begin failures++; $display("FAIL align_out: got found=%b pc=%h want 1/100", found, out_pc); end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    @(negedge clk);
    imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    mem_hold = 1'b1;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL rm_setup: got valid=%b pc=%h want 1/0", out_valid, out_pc); end
    @(negedge clk);
    mem_flush = 1'b0;
    mem_hold = 1'b0;
    out_ready = 1'b1;
    imem_req_ready = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin failures++; $display("FAIL rm_req: got valid=%b addr=%h want 0/%h", imem_req_valid, imem_req_addr, RST_PC); end
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL rm_out: got valid=%b instr=%h pc=%h want 0/0/0", out_valid, out_instr, out_pc); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #3;
    mem_flush = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_late_resp: got out_valid=%b want 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin failures++; $display("FAIL rm_restart: got valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #3;
      if (out_valid) found = 1'b1;
    end
    checks++; if (!found || out_pc !== RST_PC) begin failures++; $display("FAIL rm_first_out: got found=%b pc=%h want 1/%h", found, out_pc, RST_PC); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL provide port redirect_valid  input  1  taken jump/branch; flush and refetch.
REQ-006 SHALL provide port redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-007 SHALL provide port imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 SHALL provide port imem_req_addr  output  32  word address of request.
REQ-009 SHALL provide port imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 SHALL provide port imem_resp_valid  input  1  instruction word returned, in request order, >=1 cycle after acceptance.
REQ-011 SHALL provide port imem_resp_data  input  32  returned instruction word.
REQ-012 SHALL provide port out_valid  output  1  instruction available to decode.
REQ-013 SHALL provide port out_instr  output  32  instruction at queue head.
REQ-014 SHALL provide port out_pc  output  32  address of out_instr.
REQ-015 SHALL provide port out_ready  input  1  decode consumes head this cycle.

Function
REQ-016 Request accepted iff imem_req_valid & imem_req_ready; fetch_pc then advances by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 imem_req_valid SHALL be 1 only in state FETCH, redirect_valid=0, and count + outstanding < DEPTH (credit rule; queue never overflows).
REQ-018 imem_req_valid/addr SHALL stay stable until accepted unless redirect_valid=1.
REQ-019 Non-stale response SHALL be written to queue with resp_pc (next expected address, +4 per stored response); visible at out_* the following cycle (1-cycle response-to-out latency).
REQ-020 Output handshake out_valid & out_ready SHALL pop head; out_valid = (count != 0); out_instr/out_pc held while out_valid=1 and out_ready=0.
REQ-021 Simultaneous push and pop at count=DEPTH or count=1 SHALL keep count unchanged and order intact.
REQ-022 FSM states: BOOT, FETCH, DRAIN. BOOT -> FETCH first cycle after reset release; FETCH -> DRAIN on redirect with outstanding' > 0; FETCH stays FETCH on redirect with outstanding' = 0; DRAIN -> FETCH when drop count reaches 0.
REQ-023 On redirect_valid=1 (any state): queue cleared, count=0, fetch_pc and resp_pc <= redirect_pc, drop <= outstanding minus any response arriving that cycle; pop same cycle still counts as consumed.
REQ-024 Response arriving while drop > 0 or same cycle as redirect SHALL be discarded, drop decremented.
REQ-025 In DRAIN, no requests issued; redirect in DRAIN updates fetch_pc and stays DRAIN.
REQ-026 redirect_pc[1:0] SHALL be forced to 0.

Reset
REQ-027 While rst=0: state BOOT, fetch_pc=resp_pc=RESET_PC, count=outstanding=drop=0, imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
REQ-028 Reset mid-operation SHALL discard queue and all outstanding responses; responses arriving in BOOT ignored.

Structure
REQ-029 Shared package fetch_pkg SHALL hold state enum (BOOT/FETCH/DRAIN), RESET_PC default, word width 32, PC increment 4.
REQ-030 Queue SHALL be sub-module fetch_fifo (DEPTH x 64 bits {pc,instr}, push/pop/count, async active-low reset).
REQ-031 Estimated size 150-300 RTL lines, no latches, no combinational path from imem_resp_* to out_*.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory -> addresses 0x0,0x4,0x8...; out_pc 0x0 with matching instr two cycles after first acceptance.
REQ-033 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid=0 thereafter; out_ready=1 -> in-order drain 0x0..0xC, fetch resumes at 0x10.
REQ-034 Redirect to 0x100 with 2 outstanding -> DRAIN, both stale responses dropped, next request 0x100, first out_pc 0x100.
REQ-035 Redirect same cycle as response and out pop -> response dropped, pop completes, out_valid=0 next cycle.
REQ-036 fetch_pc 0xFFFF_FFFC accepted -> next request 0x0000_0000; redirect_pc 0x103 -> requests 0x100.
REQ-037 rst=0 pulse with 3 queued entries and 1 outstanding -> all outputs at reset values immediately; late response ignored; fetch restarts at RESET_PC.
